av_mm_master: RTL and testbench
===============================

Name: av_mm_master

Overview:
- Single-outstanding Avalon-MM master (initiator).
- Converts a simple valid/ready command port into Avalon-MM read/write transfers and returns a one-cycle response.
- Used by local controllers to reach av_univ_regs-style register slaves: fixed read latency, no waitrequest.
- Also supports generic slaves that use waitrequest and readdatavalid.

Parameters:
- DW, 32: data width in bits, multiple of 8.
- AW, 16: word address width.
- USE_WAITREQ, 0: 1 = honour avm_waitrequest; 0 = every request accepted in its first cycle.
- USE_RDV, 0: 1 = capture read data on avm_readdatavalid; 0 = fixed latency RD_LATENCY.
- RD_LATENCY, 1: cycles from read acceptance to valid readdata when USE_RDV=0; must be ≥1.
- TIMEOUT, 255: max cycles in REQ or WAIT_RD before abort; 0 disables.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_address_i  in  AW  word address
- cmd_byteenable_i  in  DW/8  byte enables
- cmd_writedata_i  in  DW  write data
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_write_o  out  1  response belongs to a write
- rsp_error_o  out  1  transfer timed out
- rsp_readdata_o  out  DW  read data (0 for writes and errors)
- avm_address  out  AW  Avalon address
- avm_byteenable  out  DW/8  Avalon byteenable
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_writedata  out  DW  Avalon writedata
- avm_waitrequest  in  1  Avalon waitrequest
- avm_readdata  in  DW  Avalon readdata
- avm_readdatavalid  in  1  Avalon readdatavalid

Behaviour:
- Clocking and reset:
  - One clock, clk_i; reset_n_i is asynchronous, active-low.
  - All outputs are registered and reset to 0, including cmd_ready_o. FSM resets to IDLE.
  - Reset mid-transfer drops the request immediately; no response is issued.
- IDLE:
  - cmd_ready_o=1, from the first clock after reset release.
  - On cmd_valid_i && cmd_ready_o at edge k: latch address, byteenable, writedata and direction; go to REQ.
  - In cycle k+1: cmd_ready_o=0 and avm_read or avm_write=1.
  - byteenable is passed unchanged, including all-zero.
- REQ:
  - Hold all avm_* outputs stable.
  - A request is accepted at an edge where avm_waitrequest=0, or at the first edge if USE_WAITREQ=0.
  - Write accepted → RSP.
  - Read accepted → WAIT_RD.
  - avm_read/avm_write deassert in the cycle after acceptance; there are never back-to-back strobes.
- WAIT_RD:
  - USE_RDV=1: capture avm_readdata at the first edge with avm_readdatavalid=1, then go to RSP.
  - USE_RDV=0: capture avm_readdata at the RD_LATENCY-th edge after the acceptance edge, then go to RSP.
  - Example, RD_LATENCY=1: read high in cycle k, data captured at the end of cycle k+1.
- RSP:
  - One cycle with rsp_valid_o=1, rsp_write_o = latched direction.
  - rsp_readdata_o = captured data for reads, 0 for writes.
  - rsp_valid_o, rsp_write_o, rsp_error_o and rsp_readdata_o return to 0 in the next cycle.
  - Next state IDLE; cmd_ready_o=1 in the cycle after RSP.
- Throughput (no wait states):
  - Write: 3 cycles per command.
  - Read: 3+RD_LATENCY cycles per command.
- Timeout (TIMEOUT>0):
  - Counter clears on entry to REQ and on entry to WAIT_RD, increments each cycle in those states.
  - On reaching TIMEOUT: deassert avm_read/avm_write, go to RSP with rsp_error_o=1 and rsp_readdata_o=0.
  - In WAIT_RD with USE_RDV=0 the timeout cannot trigger.
  - The counter saturates and never wraps.
- Simultaneous and late events:
  - avm_readdatavalid arriving in IDLE, REQ or RSP is ignored.
  - A late readdatavalid after a timeout is ignored.
  - cmd_valid_i while cmd_ready_o=0 is ignored; the command must be held by the source.
- Invariant: avm_read && avm_write is never 1.

Test Plan:
- Write, USE_WAITREQ=0: cmd addr=1, be=4'hF, data=32'hDEADBEEF at edge 0 → avm_write=1 in cycle 1 only; rsp_valid_o=1, rsp_write_o=1 in cycle 2; cmd_ready_o=1 in cycle 3.
- Read against a 1-cycle registered slave returning 32'h12345678, RD_LATENCY=1 → avm_read high exactly one cycle; rsp_readdata_o=32'h12345678 with rsp_valid_o in the following response cycle.
- Partial byteenable read, be=4'b0011, slave returns 32'h0000ABCD → rsp_readdata_o=32'h0000ABCD; avm_byteenable=4'b0011 throughout REQ.
- USE_WAITREQ=1, waitrequest held high 3 cycles → avm_address, avm_writedata and avm_write stable for 4 cycles; exactly one response.
- USE_RDV=1, TIMEOUT=8, no readdatavalid → rsp_error_o=1, rsp_readdata_o=0 exactly 8 cycles after WAIT_RD entry; a readdatavalid 2 cycles later produces no response.
- Assert reset_n_i during REQ → avm_read/avm_write=0 immediately, no rsp_valid_o; cmd_ready_o=1 one cycle after release.

Source files
------------

// File: rtl/av_mm_master.sv
// ---------------------------------------------------------------------------
// av_mm_master
//
// Single-outstanding Avalon-MM master. A command accepted on the
// valid/ready port is turned into one Avalon read or write. The result
// comes back as a one-cycle response strobe. Only one transfer is in flight
// at a time, so the command port is ready only while the FSM is idle.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o   command handshake
//   cmd_write_i                 1 = write, 0 = read
//   cmd_address_i               word address (AW bits)
//   cmd_byteenable_i            byte enables (DW/8 bits), passed through as-is
//   cmd_writedata_i             write data (DW bits)
//   rsp_valid_o                 one-cycle response strobe
//   rsp_write_o                 response belongs to a write
//   rsp_error_o                 transfer aborted by timeout
//   rsp_readdata_o              read data (0 for writes and errors)
//   avm_*                       Avalon-MM master interface
//
// Parameters
//   USE_WAITREQ  1 = honour avm_waitrequest, 0 = accept on first cycle
//   USE_RDV      1 = wait for avm_readdatavalid, 0 = fixed RD_LATENCY
//   RD_LATENCY   edges from read acceptance to data capture (>= 1)
//   TIMEOUT      max cycles spent in REQ or WAIT_RD before abort, 0 = off
//
// All outputs are registered. The FSM computes the next value of every
// output combinationally. One register stage then drives the pins.
// ---------------------------------------------------------------------------
module av_mm_master #(
    parameter int DW          = 32,
    parameter int AW          = 16,
    parameter int USE_WAITREQ = 0,
    parameter int USE_RDV     = 0,
    parameter int RD_LATENCY  = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk_i,
    input  logic              reset_n_i,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [AW-1:0]     cmd_address_i,
    input  logic [DW/8-1:0]   cmd_byteenable_i,
    input  logic [DW-1:0]     cmd_writedata_i,

    output logic              rsp_valid_o,
    output logic              rsp_write_o,
    output logic              rsp_error_o,
    output logic [DW-1:0]     rsp_readdata_o,

    output logic [AW-1:0]     avm_address,
    output logic [DW/8-1:0]   avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DW-1:0]     avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DW-1:0]     avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int BW = DW / 8;

    // The timeout counter only needs to reach TIMEOUT. The latency counter
    // only needs to reach RD_LATENCY-1.
    localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int LAT_W = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RD,
        RSP
    } state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;

    logic              cmd_ready_d;
    logic              rsp_valid_d;
    logic              rsp_write_d;
    logic              rsp_error_d;
    logic [DW-1:0]     rsp_readdata_d;
    logic [AW-1:0]     avm_address_d;
    logic [BW-1:0]     avm_byteenable_d;
    logic              avm_read_d;
    logic              avm_write_d;
    logic [DW-1:0]     avm_writedata_d;

    logic              req_accepted;
    logic              to_expire;

    // Without waitrequest support the slave takes every request on its
    // first cycle.
    assign req_accepted = (USE_WAITREQ == 0) || !avm_waitrequest;

    // The counter holds the number of edges already spent in the state.
    // It therefore reaches TIMEOUT on the edge where it still reads TIMEOUT-1.
    assign to_expire = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);

    // State and output register. Reset drops any transfer in flight
    // immediately. Every pin goes to 0, including cmd_ready_o, which rises on
    // the first edge after release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= IDLE;
            dir_q          <= 1'b0;
            to_cnt_q       <= '0;
            lat_cnt_q      <= '0;
            cmd_ready_o    <= 1'b0;
            rsp_valid_o    <= 1'b0;
            rsp_write_o    <= 1'b0;
            rsp_error_o    <= 1'b0;
            rsp_readdata_o <= '0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            to_cnt_q       <= to_cnt_d;
            lat_cnt_q      <= lat_cnt_d;
            cmd_ready_o    <= cmd_ready_d;
            rsp_valid_o    <= rsp_valid_d;
            rsp_write_o    <= rsp_write_d;
            rsp_error_o    <= rsp_error_d;
            rsp_readdata_o <= rsp_readdata_d;
            avm_address    <= avm_address_d;
            avm_byteenable <= avm_byteenable_d;
            avm_read       <= avm_read_d;
            avm_write      <= avm_write_d;
            avm_writedata  <= avm_writedata_d;
        end
    end

    // Next-state and next-output logic.
    // The response fields default to 0, so the response is a single-cycle
    // strobe. The Avalon address, byteenable and data hold their latched
    // values between transfers. Only one of avm_read_d and avm_write_d is
    // ever set, so the two strobes cannot assert together.
    always_comb begin
        state_d          = state_q;
        dir_d            = dir_q;
        to_cnt_d         = to_cnt_q;
        lat_cnt_d        = lat_cnt_q;
        cmd_ready_d      = 1'b0;
        rsp_valid_d      = 1'b0;
        rsp_write_d      = 1'b0;
        rsp_error_d      = 1'b0;
        rsp_readdata_d   = '0;
        avm_address_d    = avm_address;
        avm_byteenable_d = avm_byteenable;
        avm_read_d       = 1'b0;
        avm_write_d      = 1'b0;
        avm_writedata_d  = avm_writedata;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_o) begin
                    cmd_ready_d      = 1'b0;
                    dir_d            = cmd_write_i;
                    avm_address_d    = cmd_address_i;
                    avm_byteenable_d = cmd_byteenable_i;
                    avm_writedata_d  = cmd_writedata_i;
                    avm_read_d       = !cmd_write_i;
                    avm_write_d      = cmd_write_i;
                    to_cnt_d         = '0;
                    state_d          = REQ;
                end
            end

            REQ: begin
                avm_read_d  = avm_read;
                avm_write_d = avm_write;
                if (req_accepted) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    if (dir_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_write_d = 1'b1;
                        state_d     = RSP;
                    end else begin
                        to_cnt_d  = '0;
                        lat_cnt_d = '0;
                        state_d   = WAIT_RD;
                    end
                end else if (to_expire) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = dir_q;
                    rsp_error_d = 1'b1;
                    state_d     = RSP;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            WAIT_RD: begin
                if (USE_RDV != 0) begin
                    // Data has priority over a timeout on the same edge.
                    if (avm_readdatavalid) begin
                        rsp_valid_d    = 1'b1;
                        rsp_readdata_d = avm_readdata;
                        state_d        = RSP;
                    end else if (to_expire) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        state_d     = RSP;
                    end else if (to_cnt_q != TO_MAX) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else begin
                    // Fixed latency always completes, so no timeout applies.
                    if (lat_cnt_q == LAT_LAST) begin
                        rsp_valid_d    = 1'b1;
                        rsp_readdata_d = avm_readdata;
                        state_d        = RSP;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 1'b1;
                    end
                end
            end

            RSP: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_av_mm_master.sv
// ---------------------------------------------------------------------------
// tb_av_mm_master
//
// Directed bench for av_mm_master with two instances:
//   dutA  default parameters (no waitrequest, fixed read latency of 1),
//         served by a registered slave model that returns slaveData
//   dutB  USE_WAITREQ=1, USE_RDV=1, TIMEOUT=8, with waitrequest,
//         readdatavalid and readdata driven directly by the bench
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_av_mm_master;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        cmd_write;
    logic [15:0] cmd_address;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;

    logic        a_cmd_valid, a_cmd_ready;
    logic        a_rsp_valid, a_rsp_write, a_rsp_error;
    logic [31:0] a_rsp_rdata;
    logic [15:0] a_avm_address;
    logic [3:0]  a_avm_be;
    logic        a_avm_read, a_avm_write;
    logic [31:0] a_avm_wdata;
    logic [31:0] a_avm_rdata;

    logic        b_cmd_valid, b_cmd_ready;
    logic        b_rsp_valid, b_rsp_write, b_rsp_error;
    logic [31:0] b_rsp_rdata;
    logic [15:0] b_avm_address;
    logic [3:0]  b_avm_be;
    logic        b_avm_read, b_avm_write;
    logic [31:0] b_avm_wdata;
    logic        b_waitreq;
    logic [31:0] b_rdata;
    logic        b_rdv;

    logic [31:0] slaveData;
    int          testsRun    = 0;
    int          testsFailed = 0;
    int          rspCountA   = 0;
    int          rspCountB   = 0;
    int          rspSnap;

    always #5 clk = ~clk;

    av_mm_master #(
        .DW(32), .AW(16), .USE_WAITREQ(0), .USE_RDV(0), .RD_LATENCY(1), .TIMEOUT(255)
    ) dutA (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .cmd_valid_i       (a_cmd_valid),
        .cmd_ready_o       (a_cmd_ready),
        .cmd_write_i       (cmd_write),
        .cmd_address_i     (cmd_address),
        .cmd_byteenable_i  (cmd_be),
        .cmd_writedata_i   (cmd_wdata),
        .rsp_valid_o       (a_rsp_valid),
        .rsp_write_o       (a_rsp_write),
        .rsp_error_o       (a_rsp_error),
        .rsp_readdata_o    (a_rsp_rdata),
        .avm_address       (a_avm_address),
        .avm_byteenable    (a_avm_be),
        .avm_read          (a_avm_read),
        .avm_write         (a_avm_write),
        .avm_writedata     (a_avm_wdata),
        .avm_waitrequest   (1'b0),
        .avm_readdata      (a_avm_rdata),
        .avm_readdatavalid (1'b0)
    );

    av_mm_master #(
        .DW(32), .AW(16), .USE_WAITREQ(1), .USE_RDV(1), .RD_LATENCY(1), .TIMEOUT(8)
    ) dutB (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .cmd_valid_i       (b_cmd_valid),
        .cmd_ready_o       (b_cmd_ready),
        .cmd_write_i       (cmd_write),
        .cmd_address_i     (cmd_address),
        .cmd_byteenable_i  (cmd_be),
        .cmd_writedata_i   (cmd_wdata),
        .rsp_valid_o       (b_rsp_valid),
        .rsp_write_o       (b_rsp_write),
        .rsp_error_o       (b_rsp_error),
        .rsp_readdata_o    (b_rsp_rdata),
        .avm_address       (b_avm_address),
        .avm_byteenable    (b_avm_be),
        .avm_read          (b_avm_read),
        .avm_write         (b_avm_write),
        .avm_writedata     (b_avm_wdata),
        .avm_waitrequest   (b_waitreq),
        .avm_readdata      (b_rdata),
        .avm_readdatavalid (b_rdv)
    );

    // Registered slave for dutA. Valid data appears only in the cycle after
    // a read strobe; any other cycle returns a marker value. A capture on the
    // wrong edge therefore returns the wrong data.
    always @(posedge clk) begin
        a_avm_rdata <= a_avm_read ? slaveData : 32'hBAD0BAD0;
    end

    // Count response strobes so that duplicate or spurious responses show up.
    always @(posedge clk) begin
        if (a_rsp_valid) rspCountA++;
        if (b_rsp_valid) rspCountB++;
    end

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit toB, input logic wr, input logic [15:0] addr,
                                 input logic [3:0] be, input logic [31:0] data);
        cmd_write   = wr;
        cmd_address = addr;
        cmd_be      = be;
        cmd_wdata   = data;
        a_cmd_valid = !toB;
        b_cmd_valid = toB;
    endtask

    task automatic clearStimulus;
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
    endtask

    // Fixed-latency read on dutA: command at edge 0, read strobe in cycle 1,
    // data captured at edge 2, response in cycle 3, ready again in cycle 4.
    task automatic readA(input string tag, input logic [15:0] addr,
                         input logic [3:0] be, input logic [31:0] data);
        slaveData = data;
        checkOutput({tag, "_ready0"}, 32'(a_cmd_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, addr, be, 32'h0);
        stepCycle;
        clearStimulus;
        checkOutput({tag, "_read1"}, 32'(a_avm_read), 32'd1);
        checkOutput({tag, "_write1"}, 32'(a_avm_write), 32'd0);
        checkOutput({tag, "_addr1"}, 32'(a_avm_address), 32'(addr));
        checkOutput({tag, "_be1"}, 32'(a_avm_be), 32'(be));
        stepCycle;
        checkOutput({tag, "_read2"}, 32'(a_avm_read), 32'd0);
        checkOutput({tag, "_rspv2"}, 32'(a_rsp_valid), 32'd0);
        stepCycle;
        checkOutput({tag, "_rspv3"}, 32'(a_rsp_valid), 32'd1);
        checkOutput({tag, "_rspw3"}, 32'(a_rsp_write), 32'd0);
        checkOutput({tag, "_rdata3"}, a_rsp_rdata, data);
        stepCycle;
        checkOutput({tag, "_rspv4"}, 32'(a_rsp_valid), 32'd0);
        checkOutput({tag, "_rdata4"}, a_rsp_rdata, 32'h0);
        checkOutput({tag, "_ready4"}, 32'(a_cmd_ready), 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        slaveData = 32'h0;
        b_waitreq = 1'b0;
        b_rdv     = 1'b0;
        b_rdata   = 32'h0;
        cmd_write = 1'b0;
        cmd_address = 16'h0;
        cmd_be    = 4'h0;
        cmd_wdata = 32'h0;
        clearStimulus;

        // Reset values.
        repeat (2) stepCycle;
        checkOutput("rst_ready", 32'(a_cmd_ready), 32'd0);
        checkOutput("rst_rspv", 32'(a_rsp_valid), 32'd0);
        checkOutput("rst_strobes", 32'({a_avm_read, a_avm_write, b_avm_read, b_avm_write}), 32'd0);
        reset_n = 1'b1;
        stepCycle;
        checkOutput("rel_readyA", 32'(a_cmd_ready), 32'd1);
        checkOutput("rel_readyB", 32'(b_cmd_ready), 32'd1);

        // Write on dutA. The command is held through cycle 1 while ready is
        // low; that second presentation must be ignored.
        applyStimulus(1'b0, 1'b1, 16'h0001, 4'hF, 32'hDEADBEEF);
        stepCycle;
        checkOutput("wrA_write1", 32'(a_avm_write), 32'd1);
        checkOutput("wrA_read1", 32'(a_avm_read), 32'd0);
        checkOutput("wrA_ready1", 32'(a_cmd_ready), 32'd0);
        checkOutput("wrA_addr1", 32'(a_avm_address), 32'h1);
        checkOutput("wrA_data1", a_avm_wdata, 32'hDEADBEEF);
        checkOutput("wrA_be1", 32'(a_avm_be), 32'hF);
        stepCycle;
        clearStimulus;
        checkOutput("wrA_write2", 32'(a_avm_write), 32'd0);
        checkOutput("wrA_rspv2", 32'(a_rsp_valid), 32'd1);
        checkOutput("wrA_rspw2", 32'(a_rsp_write), 32'd1);
        checkOutput("wrA_err2", 32'(a_rsp_error), 32'd0);
        checkOutput("wrA_rdata2", a_rsp_rdata, 32'h0);
        stepCycle;
        checkOutput("wrA_rspv3", 32'(a_rsp_valid), 32'd0);
        checkOutput("wrA_ready3", 32'(a_cmd_ready), 32'd1);
        checkOutput("wrA_write3", 32'(a_avm_write), 32'd0);
        checkOutput("wrA_count", 32'(rspCountA), 32'd1);

        // Reads on dutA: full word, then partial byteenable.
        readA("rdA", 16'h0005, 4'hF, 32'h12345678);
        readA("rdA_be", 16'h0007, 4'b0011, 32'h0000ABCD);

        // An all-zero byteenable passes through unchanged.
        applyStimulus(1'b0, 1'b1, 16'h0009, 4'h0, 32'h01020304);
        stepCycle;
        clearStimulus;
        checkOutput("wrA_be0", 32'(a_avm_be), 32'h0);
        checkOutput("wrA_be0_write", 32'(a_avm_write), 32'd1);
        stepCycle;
        checkOutput("wrA_be0_rspv", 32'(a_rsp_valid), 32'd1);
        stepCycle;

        // dutB: readdatavalid while idle is ignored.
        b_rdv   = 1'b1;
        b_rdata = 32'hFFFF0000;
        stepCycle;
        b_rdv   = 1'b0;
        stepCycle;
        checkOutput("idleRdvB_rspv", 32'(b_rsp_valid), 32'd0);
        checkOutput("idleRdvB_count", 32'(rspCountB), 32'd0);

        // dutB: write held off by waitrequest for 3 cycles, accepted in the 4th.
        b_waitreq = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h0022, 4'hC, 32'hCAFEF00D);
        stepCycle;
        clearStimulus;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) b_waitreq = 1'b0;
            checkOutput($sformatf("wrB_write_c%0d", i), 32'(b_avm_write), 32'd1);
            checkOutput($sformatf("wrB_addr_c%0d", i), 32'(b_avm_address), 32'h22);
            checkOutput($sformatf("wrB_data_c%0d", i), b_avm_wdata, 32'hCAFEF00D);
            checkOutput($sformatf("wrB_be_c%0d", i), 32'(b_avm_be), 32'hC);
            checkOutput($sformatf("wrB_rspv_c%0d", i), 32'(b_rsp_valid), 32'd0);
            stepCycle;
        end
        checkOutput("wrB_write5", 32'(b_avm_write), 32'd0);
        checkOutput("wrB_rspv5", 32'(b_rsp_valid), 32'd1);
        checkOutput("wrB_rspw5", 32'(b_rsp_write), 32'd1);
        checkOutput("wrB_err5", 32'(b_rsp_error), 32'd0);
        stepCycle;
        checkOutput("wrB_rspv6", 32'(b_rsp_valid), 32'd0);
        checkOutput("wrB_ready6", 32'(b_cmd_ready), 32'd1);
        checkOutput("wrB_count", 32'(rspCountB), 32'd1);

        // dutB: read completed by readdatavalid one cycle after acceptance.
        applyStimulus(1'b1, 1'b0, 16'h0030, 4'hF, 32'h0);
        stepCycle;
        clearStimulus;
        checkOutput("rdB_read1", 32'(b_avm_read), 32'd1);
        stepCycle;
        checkOutput("rdB_read2", 32'(b_avm_read), 32'd0);
        checkOutput("rdB_rspv2", 32'(b_rsp_valid), 32'd0);
        b_rdata = 32'h0BADCAFE;
        b_rdv   = 1'b1;
        stepCycle;
        b_rdv   = 1'b0;
        b_rdata = 32'h0;
        checkOutput("rdB_rspv3", 32'(b_rsp_valid), 32'd1);
        checkOutput("rdB_rdata3", b_rsp_rdata, 32'h0BADCAFE);
        checkOutput("rdB_err3", 32'(b_rsp_error), 32'd0);
        stepCycle;
        checkOutput("rdB_ready4", 32'(b_cmd_ready), 32'd1);

        // dutB: read with no readdatavalid times out 8 cycles after WAIT_RD
        // entry. A late readdatavalid afterwards must not respond.
        b_rdata = 32'h5555AAAA;
        applyStimulus(1'b1, 1'b0, 16'h0040, 4'hF, 32'h0);
        stepCycle;
        clearStimulus;
        checkOutput("toB_read1", 32'(b_avm_read), 32'd1);
        stepCycle;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("toB_wait%0d", i), 32'(b_rsp_valid), 32'd0);
            stepCycle;
        end
        checkOutput("toB_rspv", 32'(b_rsp_valid), 32'd1);
        checkOutput("toB_err", 32'(b_rsp_error), 32'd1);
        checkOutput("toB_rdata", b_rsp_rdata, 32'h0);
        checkOutput("toB_rspw", 32'(b_rsp_write), 32'd0);
        checkOutput("toB_read", 32'(b_avm_read), 32'd0);
        stepCycle;
        rspSnap = rspCountB;
        checkOutput("toB_errclr", 32'(b_rsp_error), 32'd0);
        stepCycle;
        b_rdv   = 1'b1;
        b_rdata = 32'h77777777;
        stepCycle;
        b_rdv   = 1'b0;
        checkOutput("lateRdv_rspv1", 32'(b_rsp_valid), 32'd0);
        stepCycle;
        checkOutput("lateRdv_rspv2", 32'(b_rsp_valid), 32'd0);
        checkOutput("lateRdv_count", 32'(rspCountB), 32'(rspSnap));

        // dutB: reset asserted while a write sits in REQ under waitrequest.
        b_waitreq = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h0050, 4'hF, 32'h11112222);
        stepCycle;
        clearStimulus;
        checkOutput("rstReq_write1", 32'(b_avm_write), 32'd1);
        stepCycle;
        checkOutput("rstReq_write2", 32'(b_avm_write), 32'd1);
        rspSnap = rspCountB;
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rstReq_write", 32'(b_avm_write), 32'd0);
        checkOutput("rstReq_read", 32'(b_avm_read), 32'd0);
        checkOutput("rstReq_ready", 32'(b_cmd_ready), 32'd0);
        checkOutput("rstReq_rspv", 32'(b_rsp_valid), 32'd0);
        stepCycle;
        reset_n   = 1'b1;
        b_waitreq = 1'b0;
        checkOutput("rstRel_ready0", 32'(b_cmd_ready), 32'd0);
        stepCycle;
        checkOutput("rstRel_ready1", 32'(b_cmd_ready), 32'd1);
        checkOutput("rstRel_rspv", 32'(b_rsp_valid), 32'd0);
        checkOutput("rstRel_count", 32'(rspCountB), 32'(rspSnap));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
